// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs buffered long-latency results.
// Optional REGFILE_ARB_BYPASS_EN adds write-cycle forwarding and early busy release.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
`ifdef REGFILE_ARB_BYPASS_EN
  output logic        rs1_byp_valid,
  output logic [31:0] rs1_byp_data,
  output logic        rs2_byp_valid,
  output logic [31:0] rs2_byp_data,
`endif
  output logic        stall_req,
  output logic        ovf_err,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_STARVED = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic [4:0]    fifo_addr [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  logic          grant_wb;
  logic          grant_lu;
  logic          wb_drop;

  logic [31:0]   pending;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign lu_ready  = !full;
  assign push      = lu_valid && !full;
  assign head_addr = fifo_addr[rd_ptr[AW-1:0]];
  assign head_data = fifo_data[rd_ptr[AW-1:0]];
  assign stall_req = (state == ST_STARVED);

  // Grant selection: pipeline first unless the FIFO head is starving
  always_comb begin
    grant_wb = 1'b0;
    grant_lu = 1'b0;
    wb_drop  = 1'b0;
    if (state == ST_STARVED) begin
      grant_lu = !empty;
      wb_drop  = wb_valid;
    end else if (wb_valid) begin
      grant_wb = 1'b1;
    end else begin
      grant_lu = !empty;
    end
  end

  // Starvation counter and NORMAL/STARVED next state
  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    if (empty || grant_lu) begin
      cnt_nxt = '0;
    end else if (cnt != CW'(STARVE_LIMIT)) begin
      cnt_nxt = cnt + 1'b1;
    end
    if (empty) begin
      state_nxt = ST_NORMAL;
    end else if (cnt_nxt >= CW'(STARVE_LIMIT)) begin
      state_nxt = ST_STARVED;
    end
  end

  // Scoreboard update masks; a same-cycle set overrides the clear
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && issue_addr != 5'd0) begin
      set_mask = 32'b1 << issue_addr;
    end
    if (grant_lu && head_addr != 5'd0) begin
      clr_mask = 32'b1 << head_addr;
    end
  end

  // FIFO storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[AW-1:0]] <= lu_addr;
      fifo_data[wr_ptr[AW-1:0]] <= lu_data;
    end
  end

  // FIFO pointers, FSM, scoreboard and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      state   <= ST_NORMAL;
      cnt     <= '0;
      pending <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (grant_lu) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= (pending & ~clr_mask) | set_mask;
      if ((lu_valid && full) || wb_drop) begin
        ovf_err <= 1'b1;
      end
    end
  end

  // Registered write port toward the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else if (grant_wb) begin
      rf_we   <= (wb_addr != 5'd0);
      rf_addr <= wb_addr;
      rf_data <= wb_data;
    end else if (grant_lu) begin
      rf_we   <= (head_addr != 5'd0);
      rf_addr <= head_addr;
      rf_data <= head_data;
    end else begin
      rf_we   <= 1'b0;
    end
  end

`ifdef REGFILE_ARB_BYPASS_EN
  // Busy lookups with early release on the clearing grant
  always_comb begin
    rs1_busy = pending[rs1_addr] && (rs1_addr != 5'd0) &&
               !clr_mask[rs1_addr];
    rs2_busy = pending[rs2_addr] && (rs2_addr != 5'd0) &&
               !clr_mask[rs2_addr];
  end

  // Forward the write the regfile has not yet absorbed
  always_comb begin
    rs1_byp_valid = rf_we && (rf_addr == rs1_addr) &&
                    (rs1_addr != 5'd0);
    rs2_byp_valid = rf_we && (rf_addr == rs2_addr) &&
                    (rs2_addr != 5'd0);
    rs1_byp_data  = rf_data;
    rs2_byp_data  = rf_data;
  end
`else
  // Busy lookups straight from the scoreboard
  always_comb begin
    rs1_busy = pending[rs1_addr] && (rs1_addr != 5'd0);
    rs2_busy = pending[rs2_addr] && (rs2_addr != 5'd0);
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Expected values hand-derived per cycle.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        stall_req;
  logic        ovf_err;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
`ifdef REGFILE_ARB_BYPASS_EN
  logic        rs1_byp_valid;
  logic [31:0] rs1_byp_data;
  logic        rs2_byp_valid;
  logic [31:0] rs2_byp_data;
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .FIFO_DEPTH(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .lu_valid(lu_valid),
    .lu_addr(lu_addr),
    .lu_data(lu_data),
    .lu_ready(lu_ready),
    .issue_valid(issue_valid),
    .issue_addr(issue_addr),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
`ifdef REGFILE_ARB_BYPASS_EN
    .rs1_byp_valid(rs1_byp_valid),
    .rs1_byp_data(rs1_byp_data),
    .rs2_byp_valid(rs2_byp_valid),
    .rs2_byp_data(rs2_byp_data),
`endif
    .stall_req(stall_req),
    .ovf_err(ovf_err),
    .rf_we(rf_we),
    .rf_addr(rf_addr),
    .rf_data(rf_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    lu_valid    = 1'b0;
    lu_addr     = '0;
    lu_data     = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    rs1_addr = 5'd9;
    #1;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_ready", 32'(lu_ready), 32'd1);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_busy", 32'(rs1_busy), 32'd0);
    chk("rst_addr", 32'(rf_addr), 32'd0);

    // plain pipeline writeback
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    wb_data  = 32'hDEADBEEF;
    tick();
    wb_valid = 1'b0;
    chk("wb_we", 32'(rf_we), 32'd1);
    chk("wb_addr", 32'(rf_addr), 32'd5);
    chk("wb_data", rf_data, 32'hDEADBEEF);
    tick();
    chk("wb_we_off", 32'(rf_we), 32'd0);

    // scoreboard set, long-latency completion, clear
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    tick();
    issue_valid = 1'b0;
    rs2_addr    = 5'd9;
    #1;
    chk("sb_busy1", 32'(rs1_busy), 32'd1);
    chk("sb_busy2", 32'(rs2_busy), 32'd1);
    tick();
    chk("sb_hold", 32'(rs1_busy), 32'd1);
    lu_valid = 1'b1;
    lu_addr  = 5'd9;
    lu_data  = 32'h12;
    tick();
    lu_valid = 1'b0;
    #1;
    chk("sb_grant_busy", 32'(rs1_busy), BYP ? 32'd0 : 32'd1);
    chk("sb_grant_we", 32'(rf_we), 32'd0);
    tick();
    chk("lu_we", 32'(rf_we), 32'd1);
    chk("lu_addr", 32'(rf_addr), 32'd9);
    chk("lu_data", rf_data, 32'h12);
    chk("sb_clr", 32'(rs1_busy), 32'd0);

    // starvation of a single FIFO entry
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    wb_valid = 1'b1;
    wb_addr  = 5'd1;
    wb_data  = 32'h1;
    lu_valid = 1'b1;
    lu_addr  = 5'd10;
    lu_data  = 32'hA5;
    tick();
    lu_valid = 1'b0;
    repeat (7) tick();
    chk("stv_pre", 32'(stall_req), 32'd0);
    tick();
    chk("stv_on", 32'(stall_req), 32'd1);
    chk("stv_wbaddr", 32'(rf_addr), 32'd1);
    chk("stv_ovf0", 32'(ovf_err), 32'd0);
    tick();
    chk("stv_we", 32'(rf_we), 32'd1);
    chk("stv_addr", 32'(rf_addr), 32'd10);
    chk("stv_data", rf_data, 32'hA5);
    chk("stv_ovf", 32'(ovf_err), 32'd1);
    tick();
    chk("stv_off", 32'(stall_req), 32'd0);
    chk("stv_drop", 32'(rf_we), 32'd0);
    tick();
    chk("stv_resume", 32'(rf_we), 32'd1);
    chk("stv_res_addr", 32'(rf_addr), 32'd1);
    wb_valid = 1'b0;

    // mid-operation reset clears FIFO, pending bits and ovf
    issue_valid = 1'b1;
    issue_addr  = 5'd12;
    wb_valid    = 1'b1;
    lu_valid    = 1'b1;
    lu_addr     = 5'd4;
    lu_data     = 32'h44;
    tick();
    issue_valid = 1'b0;
    lu_valid    = 1'b0;
    do_reset();
    wb_valid = 1'b0;
    rs1_addr = 5'd12;
    #1;
    chk("mrst_busy", 32'(rs1_busy), 32'd0);
    chk("mrst_ovf", 32'(ovf_err), 32'd0);
    chk("mrst_we", 32'(rf_we), 32'd0);
    tick();
    chk("mrst_flush", 32'(rf_we), 32'd0);

    // fill to full, reject 5th push while popping, drain in order
    wb_valid = 1'b1;
    wb_addr  = 5'd2;
    wb_data  = 32'h2;
    for (int i = 0; i < 4; i++) begin
      lu_valid = 1'b1;
      lu_addr  = 5'(11 + i);
      lu_data  = 32'hC0 + 32'(11 + i);
      tick();
      if (i == 2) chk("full_ready3", 32'(lu_ready), 32'd1);
      if (i == 3) chk("full_ready4", 32'(lu_ready), 32'd0);
    end
    wb_valid = 1'b0;
    lu_addr  = 5'd15;
    lu_data  = 32'hCF;
    tick();
    lu_valid = 1'b0;
    chk("full_ovf", 32'(ovf_err), 32'd1);
    chk("full_ready", 32'(lu_ready), 32'd1);
    chk("drain0_addr", 32'(rf_addr), 32'd11);
    chk("drain0_data", rf_data, 32'hCB);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain_we", 32'(rf_we), 32'd1);
      chk("drain_addr", 32'(rf_addr), 32'(11 + i));
    end
    tick();
    chk("drain_end", 32'(rf_we), 32'd0);

    // address 0 pops without writing or marking
    do_reset();
    lu_valid    = 1'b1;
    lu_addr     = 5'd0;
    lu_data     = 32'hFF;
    issue_valid = 1'b1;
    issue_addr  = 5'd0;
    tick();
    lu_valid    = 1'b0;
    issue_valid = 1'b0;
    rs1_addr    = 5'd0;
    #1;
    chk("z_busy", 32'(rs1_busy), 32'd0);
    tick();
    chk("z_we", 32'(rf_we), 32'd0);
    lu_valid = 1'b1;
    lu_addr  = 5'd3;
    lu_data  = 32'h77;
    tick();
    lu_valid = 1'b0;
    tick();
    chk("z_next_we", 32'(rf_we), 32'd1);
    chk("z_next_addr", 32'(rf_addr), 32'd3);
    chk("z_next_data", rf_data, 32'h77);
    rs2_addr = 5'd3;
    #1;
    chk("z_rs2_busy", 32'(rs2_busy), 32'd0);
`ifdef REGFILE_ARB_BYPASS_EN
    chk("byp_valid", 32'(rs2_byp_valid), 32'd1);
    chk("byp_data", rs2_byp_data, 32'h77);
    chk("byp_rs1", 32'(rs1_byp_valid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
